// File: rtl/mmm_pkg.sv
// Shared definitions for the Montgomery multiplier sequencer.
package mmm_pkg;

  // Default operand width, which is also the number of MMM iterations.
  localparam int MMM_WIDTH = 10;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    ITER,
    SUB,
    DONE
  } mmm_state_t;

  // Width of the bit counter. The result is never below 1, so small widths
  // still produce a legal vector.
  function automatic int mmm_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mmm_bit_cnt.sv
// Bit counter for the MMM sequencer. This is a clearable, gated up-counter
// that raises tc_o at WIDTH-1 and then holds there, so it never wraps.
module mmm_bit_cnt
  import mmm_pkg::*;
#(
  parameter int WIDTH = MMM_WIDTH,
  parameter int CW    = mmm_cnt_w(MMM_WIDTH)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  assign tc_o  = (cnt_q == CW'(WIDTH - 1));
  assign cnt_o = cnt_q;

  // Count register: clear has priority over increment, and the count
  // saturates at the terminal value.
  always_ff @(posedge clk or negedge rstb) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values from before the edge.
    if (!rstb) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mmm_seq.sv
// Sequencer for the bit-serial Montgomery modular multiplier.
// The optional final conditional subtraction state is compiled in when the
// macro MMM_FINAL_SUB_EN is defined. Without it, ITER goes straight to DONE
// and sub_o is tied low.
module mmm_seq
  import mmm_pkg::*;
#(
  parameter int WIDTH = MMM_WIDTH
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         en,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         src_sel_i,
  input  logic                         ge_i,
  output logic                         rst_mmm_o,
  output logic                         ld_r_o,
  output logic                         lock_o,
  output logic                         step_o,
  output logic [mmm_cnt_w(WIDTH)-1:0]  bit_idx_o,
  output logic                         sub_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int CW = mmm_cnt_w(WIDTH);

  mmm_state_t    state_q;
  logic          src_q;
  logic [CW-1:0] cnt;
  logic          cnt_tc;
  logic          cnt_clr;
  logic          cnt_inc;

  // Abort clears the counter regardless of en. CLEAR clears it only on an
  // enabled cycle, so a stall holds the count.
  assign cnt_clr = abort_i || (en && (state_q == CLEAR));
  assign cnt_inc = en && (state_q == ITER);

  mmm_bit_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_cnt (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  // State register and latched R source. Abort wins over everything but
  // reset, and en=0 freezes all progress.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      src_q   <= 1'b0;
    end else if (abort_i) begin
      state_q <= IDLE;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= CLEAR;
            src_q   <= src_sel_i;
          end
        end
        CLEAR: state_q <= LOAD;
        LOAD:  state_q <= ITER;
        ITER: begin
          if (cnt_tc) begin
`ifdef MMM_FINAL_SUB_EN
            state_q <= SUB;
`else
            state_q <= DONE;
`endif
          end
        end
        SUB:     state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MMM_FINAL_SUB_EN
  logic sub_hit;
  assign sub_hit = (state_q == SUB) && ge_i;
`else
  logic sub_hit;
  logic ge_unused;
  assign sub_hit   = 1'b0;
  assign ge_unused = ge_i;
`endif

  // Moore output decode from the state and counter. The strobes are gated
  // by en, and the abort clear strobe is not.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    rst_mmm_o = 1'b1;
    ld_r_o    = 1'b0;
    lock_o    = 1'b0;
    step_o    = 1'b0;
    sub_o     = 1'b0;
    done_o    = 1'b0;
    bit_idx_o = '0;
    busy_o    = (state_q != IDLE);
    case (state_q)
      CLEAR: rst_mmm_o = !en;
      LOAD: begin
        ld_r_o = en;
        lock_o = src_q;
      end
      ITER: begin
        step_o    = en;
        ld_r_o    = en;
        bit_idx_o = cnt;
      end
      SUB: begin
        sub_o  = en && sub_hit;
        ld_r_o = en && sub_hit;
      end
      DONE:    done_o = en;
      default: ;
    endcase
    if (abort_i) begin
      rst_mmm_o = 1'b0;
    end
  end

endmodule

// File: doc/mmm_seq.md
# mmm_seq

Sequencer for the bit-serial Montgomery modular multiplier (MMM) datapath in the RSA core. It accepts a start request and clears the MMM accumulator. It loads the initial R operand from either the precomputed r-value register or the A bus, then steps the datapath through WIDTH iterations and an optional final conditional subtraction, and reports completion to the exponentiation layer above with a single-cycle done pulse.

## Interface
- WIDTH, 10, operand width in bits and the number of MMM iterations (≥2); counter width is derived as $clog2(WIDTH)
- clk  in  1  system clock, rising edge
- rstb  in  1  asynchronous active-low reset
- en  in  1  global clock enable; 0 freezes the block
- start_i  in  1  request one multiplication; sampled only in IDLE
- abort_i  in  1  synchronous abort; highest priority after rstb
- src_sel_i  in  1  initial R source: 1 = r-value register, 0 = A bus
- ge_i  in  1  datapath comparator: result ≥ modulus (used in SUB only)
- rst_mmm_o  out  1  active-low synchronous clear strobe to the MMM datapath
- ld_r_o  out  1  R register load strobe
- lock_o  out  1  R source select that accompanies ld_r_o
- step_o  out  1  one MMM iteration strobe
- bit_idx_o  out  $clog2(WIDTH)  index of the current exponent/operand bit
- sub_o  out  1  apply final subtraction this cycle
- busy_o  out  1  high from start accept until DONE exits
- done_o  out  1  single-cycle completion pulse

## Operation
- States: IDLE, CLEAR, LOAD, ITER, SUB, DONE. The state is held in a register. All outputs are Moore, decoded from the state register and bit counter, and gated by en.
- IDLE: busy_o=0. If start_i=1 and en=1, the block moves to CLEAR on the next edge.
- CLEAR: rst_mmm_o=0 for one cycle. The bit counter clears to 0. Next state is LOAD.
- LOAD: ld_r_o=1 and lock_o=src_sel_i, with src_sel_i sampled at start accept and held in a register. Next state is ITER.
- ITER: step_o=1, ld_r_o=1, lock_o=0 (the accumulator reloads from A). bit_idx_o = counter value.
  - The counter increments from 0 to WIDTH-1.
  - At WIDTH-1 the next state is SUB, or DONE if the final-subtract feature is compiled out.
- SUB: sub_o=ge_i and ld_r_o=ge_i, lock_o=0. Next state is DONE.
- DONE: done_o=1 and busy_o=1 for one cycle. Next state is IDLE.
- en=0 in any state:
  - The state and counter hold.
  - ld_r_o, step_o, sub_o and done_o are forced to 0.
  - rst_mmm_o is forced to 1.
  - busy_o keeps its value.
  - When en returns, operation resumes exactly where it stopped.
- start_i while busy_o=1 is ignored. No queuing.
- abort_i=1 (en-independent): the next state is IDLE and the counter clears. No done_o. In that cycle rst_mmm_o=0 so the datapath does not hold a partial result. abort_i in IDLE has no effect other than that clear strobe.
- Simultaneous start_i and abort_i in IDLE: abort wins and start is dropped.
- The counter never wraps inside ITER. The terminal count is compared against WIDTH-1 exactly.

## Timing
- Reset values: state IDLE, counter 0, src register 0, rst_mmm_o=1, ld_r_o=0, lock_o=0, step_o=0, bit_idx_o=0, sub_o=0, busy_o=0, done_o=0.
- With start accepted at edge 0 and en held at 1:
  - CLEAR in cycle 1, LOAD in cycle 2.
  - ITER in cycles 3..WIDTH+2.
  - SUB in cycle WIDTH+3.
  - done_o in cycle WIDTH+4 (WIDTH+3 without SUB).
- Total is WIDTH+5 cycles start-to-idle (WIDTH+4 without SUB). Each en=0 cycle adds one cycle.
- A back-to-back start_i is accepted at the earliest in the cycle after DONE, i.e. in IDLE.
- rstb assertion mid-operation returns to reset values immediately (asynchronously). No done_o is issued.

## Configuration
- MMM_FINAL_SUB_EN defined: the SUB state exists and behaves as described above.
- MMM_FINAL_SUB_EN undefined: the SUB state is removed. ITER goes directly to DONE, sub_o is tied to 0, and ge_i is unused.

## Structure
- Shared package mmm_pkg holds:
  - the state enum mmm_state_t (IDLE, CLEAR, LOAD, ITER, SUB, DONE);
  - the default operand width constant MMM_WIDTH=10;
  - the derived counter width function/constant.
- One sub-module, mmm_bit_cnt: a clearable, enable-gated up-counter with a terminal-count flag at WIDTH-1. It uses the same clk/rstb.
- mmm_seq contains the FSM, the src_sel register and the output decode.

## Test plan
- Reset, then start_i=1 for one cycle with src_sel_i=1, en=1, WIDTH=10 and MMM_FINAL_SUB_EN defined:
  - rst_mmm_o low in cycle 1;
  - ld_r_o=1 and lock_o=1 in cycle 2;
  - step_o high for 10 cycles with bit_idx_o 0..9;
  - sub_o=ge_i in cycle 13;
  - done_o in cycle 14, busy_o low in cycle 15.
- Same run with ge_i=0: sub_o=0 and ld_r_o=0 in cycle 13; done_o is still in cycle 14.
- en=0 for 3 cycles while bit_idx_o=4:
  - strobes are 0 and bit_idx_o holds at 4;
  - done_o arrives 3 cycles later, i.e. cycle 17.
- abort_i at bit_idx_o=6: rst_mmm_o=0 for one cycle, then IDLE, busy_o=0 and bit_idx_o=0, with no done_o.
- start_i pulsed during ITER: ignored, only one done_o. A second start_i in the cycle after done_o is accepted.
- rstb asserted at bit_idx_o=2: all outputs return to reset values without waiting for a clk edge.
- With MMM_FINAL_SUB_EN undefined: done_o in cycle 13 and sub_o never asserts.
